// File: rtl/voice_vel_ctrl.sv
// Note-event queue + per-voice velocity table; commits one queued event per frame (E0 sample -> E3 commit), level path 2 cycles.
// Backpressure: ev_ready drops when the FIFO is full; an event offered while full is discarded and flagged on ev_drop.
module voice_vel_ctrl #(
  parameter int VOICES  = 8,
  parameter int V_WIDTH = 3,
  parameter int E_WIDTH = 3,
  parameter int VEL_W   = 8,
  parameter int LVL_W   = 8,
  parameter int FIFO_AW = 2
) (
  input  logic                       OSC_CLK,
  input  logic                       iRST,
  input  logic                       ev_valid,
  output logic                       ev_ready,
  input  logic                       ev_on,
  input  logic [V_WIDTH-1:0]         ev_key_adr,
  input  logic [VEL_W-1:0]           ev_vel,
  input  logic                       frame_start,
  input  logic [V_WIDTH+E_WIDTH-1:0] xxxx,
  input  logic [LVL_W-1:0]           level_mul,
  input  logic [1:0]                 vel_mode,
  output logic [VOICES-1:0]          keys_on,
  output logic                       note_on_pulse,
  output logic [V_WIDTH-1:0]         note_key_adr,
  output logic [LVL_W-1:0]           level_mul_vel,
  output logic [V_WIDTH+E_WIDTH-1:0] slot_out,
  output logic                       ev_drop
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam int ENT_W = 1 + V_WIDTH + VEL_W;
  localparam int NV    = 2**V_WIDTH;
  localparam int SW    = V_WIDTH + E_WIDTH;
  localparam int PW    = LVL_W + VEL_W + 1;
  localparam int QW    = 2*VEL_W + 2;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_POP, S_CALC, S_COMMIT} state_t;
  state_t state, state_nxt;

  logic [ENT_W-1:0]   fifo_mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               wr_en, pop, empty;

  logic               hold_on;
  logic [V_WIDTH-1:0] hold_key;
  logic [VEL_W-1:0]   hold_vel;
  logic [VEL_W-1:0]   vel_eff, vel_calc;
  logic [VEL_W:0]     sq_p1;
  logic [QW-1:0]      sq;

  logic [VEL_W-1:0]   vel_table [NV];
  logic [NV-1:0]      gate;

  logic [V_WIDTH-1:0] voice;
  logic [VEL_W-1:0]   vel_s1;
  logic [LVL_W-1:0]   lvl_s1;
  logic [SW-1:0]      slot_s1;
  logic [VEL_W:0]     vel_p1;
  logic [PW-1:0]      product;

  // count never exceeds DEPTH, so its MSB alone marks full
  assign ev_ready = !count[FIFO_AW];
  assign empty    = (count == '0);
  assign wr_en    = ev_valid && ev_ready;
  assign pop      = (state == S_POP);
  assign keys_on  = gate[VOICES-1:0];
  assign voice    = xxxx[SW-1 -: V_WIDTH];

  always_ff @(posedge OSC_CLK) begin
    if (wr_en) fifo_mem[wr_ptr] <= {ev_on, ev_key_adr, ev_vel};
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ev_drop <= 1'b0;
    end else begin
      ev_drop <= ev_valid && !ev_ready;
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!empty) state_nxt = S_WAIT;
      S_WAIT:   if (empty) state_nxt = S_IDLE;
                else if (frame_start) state_nxt = S_POP;
      S_POP:    state_nxt = S_CALC;
      S_CALC:   state_nxt = S_COMMIT;
      S_COMMIT: state_nxt = empty ? S_IDLE : S_WAIT;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    sq_p1 = {1'b0, hold_vel} + {{VEL_W{1'b0}}, 1'b1};
    sq    = {{(VEL_W+1){1'b0}}, sq_p1} * {{(VEL_W+1){1'b0}}, sq_p1};
    case (vel_mode)
      2'd0:    vel_calc = '1;
      2'd2:    vel_calc = VEL_W'((sq - {{(QW-1){1'b0}}, 1'b1}) >> VEL_W);
      default: vel_calc = hold_vel;
    endcase
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      hold_on       <= 1'b0;
      hold_key      <= '0;
      hold_vel      <= '0;
      vel_eff       <= '0;
      gate          <= '0;
      note_on_pulse <= 1'b0;
      note_key_adr  <= '0;
      for (int i = 0; i < NV; i++) vel_table[i] <= '1;
    end else begin
      note_on_pulse <= (state == S_COMMIT) && hold_on;
      if (state == S_POP) {hold_on, hold_key, hold_vel} <= fifo_mem[rd_ptr];
      if (state == S_CALC) vel_eff <= vel_calc;
      if (state == S_COMMIT) begin
        note_key_adr   <= hold_key;
        gate[hold_key] <= hold_on;
        if (hold_on) vel_table[hold_key] <= vel_eff;
      end
    end
  end

  // stage-1 read forwards the velocity being committed on the same edge
  always_comb begin
    vel_p1  = {1'b0, vel_s1} + {{VEL_W{1'b0}}, 1'b1};
    product = {{(VEL_W+1){1'b0}}, lvl_s1} * {{LVL_W{1'b0}}, vel_p1};
  end

  always_ff @(posedge OSC_CLK or posedge iRST) begin
    if (iRST) begin
      vel_s1        <= '0;
      lvl_s1        <= '0;
      slot_s1       <= '0;
      level_mul_vel <= '0;
      slot_out      <= '0;
    end else begin
      if ((state == S_COMMIT) && hold_on && (hold_key == voice)) vel_s1 <= vel_eff;
      else vel_s1 <= vel_table[voice];
      lvl_s1        <= level_mul;
      slot_s1       <= xxxx;
      level_mul_vel <= LVL_W'(product >> VEL_W);
      slot_out      <= slot_s1;
    end
  end

endmodule
